// File: rtl/sha_mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port among NUM_REQ SHA-256 engines,
// with bounded burst locking and a fixed two-cycle read-response pipeline.
module sha_mem_port_arbiter #(
  parameter int unsigned NUM_REQ   = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_clk,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data
);

  localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned      CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("sha_mem_port_arbiter: NUM_REQ must be in 2..16");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("sha_mem_port_arbiter: MAX_BURST must be at least 1");
  end

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_owner_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_nxt;
  logic [CNT_W-1:0] w_burst_cnt_inc;

  logic             w_gnt_found;
  logic             w_accept;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [IDX_W-1:0] w_gnt_idx_inc;
  logic [IDX_W:0]   w_scan;
  logic             w_gnt_we;
  logic             w_gnt_lock;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_wdata;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_a_rd;
  logic [IDX_W-1:0]  r_a_idx;
  logic              r_b_rd;
  logic [IDX_W-1:0]  r_b_idx;

  // Grant selection: owner only while locked, otherwise first valid at or after ptr.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    if (r_state == S_LOCKED) begin
      w_gnt_found = req_valid[r_owner];
      w_gnt_idx   = r_owner;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        w_scan = {1'b0, r_ptr} + (IDX_W + 1)'(i);
        if (w_scan >= NUM_EXT) begin
          w_scan = w_scan - NUM_EXT;
        end
        if (!w_gnt_found && req_valid[w_scan[IDX_W-1:0]]) begin
          w_gnt_found = 1'b1;
          w_gnt_idx   = w_scan[IDX_W-1:0];
        end
      end
    end
  end

  assign w_accept        = w_gnt_found & reset_n;
  assign w_gnt_idx_inc   = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
  assign w_burst_cnt_inc = r_burst_cnt + 1'b1;

  always_comb begin
    w_gnt_we    = 1'b0;
    w_gnt_lock  = 1'b0;
    w_gnt_addr  = '0;
    w_gnt_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == IDX_W'(i)) begin
        w_gnt_we    = req_we[i];
        w_gnt_lock  = req_lock[i];
        w_gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_gnt_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ptr_nxt = w_gnt_idx_inc;
          if (w_gnt_lock && (MAX_BURST > 1)) begin
            w_state_nxt     = S_LOCKED;
            w_owner_nxt     = w_gnt_idx;
            w_burst_cnt_nxt = CNT_W'(1);
          end
        end
      end
      S_LOCKED: begin
        if (!w_accept) begin
          w_state_nxt     = S_IDLE;
          w_burst_cnt_nxt = '0;
        end else if (!w_gnt_lock || (w_burst_cnt_inc == MAX_CNT)) begin
          // Forced or voluntary release hands the scan start to the engine after the owner.
          w_state_nxt     = S_IDLE;
          w_ptr_nxt       = w_gnt_idx_inc;
          w_burst_cnt_nxt = '0;
        end else begin
          w_burst_cnt_nxt = w_burst_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (w_accept) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
    if (r_b_rd) begin
      rsp_valid[r_b_idx] = 1'b1;
    end
  end

  // Stage A drives the memory port; stage B lines up with the memory's one-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_a_rd      <= 1'b0;
      r_a_idx     <= '0;
      r_b_rd      <= 1'b0;
      r_b_idx     <= '0;
    end else begin
      r_mem_we <= w_accept & w_gnt_we;
      r_a_rd   <= w_accept & ~w_gnt_we;
      if (w_accept) begin
        r_mem_addr  <= w_gnt_addr;
        r_mem_wdata <= w_gnt_wdata;
        r_a_idx     <= w_gnt_idx;
      end
      r_b_rd  <= r_a_rd;
      r_b_idx <= r_a_idx;
    end
  end

  assign mem_clk        = clk;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign rsp_rdata      = mem_read_data;

endmodule
